// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with a
// start/done handshake and registered S/Cout/V that hold until the next completion.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             mode_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             v_r;

    logic             y_bit_s;
    logic             sum_bit_s;
    logic             c_next_s;
    logic             last_bit_s;

    // Full-adder slice for the current bit position.
    always_comb begin
        y_bit_s    = b_sh_r[0] ^ mode_r;
        sum_bit_s  = a_sh_r[0] ^ y_bit_s ^ carry_r;
        c_next_s   = majority(a_sh_r[0], y_bit_s, carry_r);
        last_bit_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus handshake flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Operand/sum shift registers and result latch; results are captured on
    // the final RUN edge so they are valid together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            sum_sh_r <= '0;
            cnt_r    <= '0;
            mode_r   <= 1'b0;
            carry_r  <= 1'b0;
            s_r      <= '0;
            cout_r   <= 1'b0;
            v_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r   <= A;
                        b_sh_r   <= B;
                        sum_sh_r <= '0;
                        mode_r   <= Mode;
                        carry_r  <= Mode;
                        cnt_r    <= '0;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= {sum_bit_s, sum_sh_r[WIDTH-1:1]};
                    carry_r  <= c_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        // carry_r here is the carry into the MSB
                        s_r    <= {sum_bit_s, sum_sh_r[WIDTH-1:1]};
                        cout_r <= c_next_s;
                        v_r    <= carry_r ^ c_next_s;
                    end
                end
                DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign S    = s_r;
    assign Cout = cout_r;
    assign V    = v_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vectors, randomized operations
// against an arithmetic reference model, handshake timing and reset behaviour.
module tb_serial_addsub;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         Mode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         V;

    int n_cmp;
    int n_fail;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Mode  (Mode),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {V, Cout, S} from plain integer two's-complement arithmetic.
    function automatic logic [W+1:0] model(input int a, input int b, input int m);
        int bb, full, s, c, sa, sb, ss, v;
        bb   = (m != 0) ? ((~b) & MASK) : b;
        full = a + bb + ((m != 0) ? 1 : 0);
        s    = full & MASK;
        c    = (full >> W) & 1;
        sa   = (a >> (W - 1)) & 1;
        sb   = (bb >> (W - 1)) & 1;
        ss   = (s >> (W - 1)) & 1;
        v    = ((sa == sb) && (ss != sa)) ? 1 : 0;
        return {v[0], c[0], s[W-1:0]};
    endfunction

    // Launches one operation from a negedge in IDLE; scrambles inputs during RUN;
    // returns at the negedge where done is seen, or cycles = -1 on timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output int cycles);
        start = 1'b1; A = a; B = b; Mode = m;
        @(posedge clk);
        cycles = -1;
        for (int j = 0; j < 3 * W + 10; j++) begin
            @(negedge clk);
            start = 1'b0;
            A = W'($urandom); B = W'($urandom); Mode = 1'($urandom);
            if (done) begin
                cycles = j;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; Mode = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, S, Cout, V} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b done=%b S=%b Cout=%b V=%b, required all 0",
                     busy, done, S, Cout, V);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] av [6] = '{4'b0101, 4'b0111, 4'b0011, 4'b0000, 4'b1111, 4'b0000};
        logic [W-1:0] bv [6] = '{4'b0011, 4'b0010, 4'b0101, 4'b0000, 4'b0001, 4'b1000};
        logic         mv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W+1:0] ev [6] = '{{1'b1, 1'b0, 4'b1000}, {1'b0, 1'b1, 4'b0101},
                                 {1'b0, 1'b0, 4'b1110}, {1'b0, 1'b1, 4'b0000},
                                 {1'b0, 1'b1, 4'b0000}, {1'b1, 1'b0, 4'b1000}};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            do_op(av[i], bv[i], mv[i], cyc);
            n_cmp++;
            if (cyc !== W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: done after %0d cycles, required %0d", i, cyc, W);
            end
            n_cmp++;
            if ({V, Cout, S} !== ev[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: V,Cout,S=%b, required %b", i, {V, Cout, S}, ev[i]);
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00 || {V, Cout, S} !== ev[i]) begin
                n_fail++;
                $display("FAIL directed_after_done[%0d]: busy=%b done=%b V,Cout,S=%b, required 0 0 %b",
                         i, busy, done, {V, Cout, S}, ev[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         m;
        logic [W+1:0] exp;
        int           cyc;
        int           idle;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); m = 1'($urandom);
            exp = model(int'(a), int'(b), int'(m));
            do_op(a, b, m, cyc);
            n_cmp++;
            if (cyc !== W || {V, Cout, S} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] a=%b b=%b m=%b: cycles=%0d V,Cout,S=%b, required %0d %b",
                         i, a, b, m, cyc, {V, Cout, S}, W, exp);
            end
            idle = $urandom_range(1, 4);
            for (int k = 0; k < idle; k++) begin
                @(negedge clk);
                A = W'($urandom); B = W'($urandom); Mode = 1'($urandom);
            end
            n_cmp++;
            if ({V, Cout, S} !== exp || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_hold[%0d]: busy=%b V,Cout,S=%b, required 0 %b", i, busy, {V, Cout, S}, exp);
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [W+1:0] exp;
        int           dones;
        int           bad_busy;
        exp = model(6, 9, 0);
        start = 1'b1; A = 4'd6; B = 4'd9; Mode = 1'b0;
        @(posedge clk);
        dones = 0; bad_busy = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            start = (j == 1) ? 1'b1 : 1'b0;
            A = 4'd15; B = 4'd15; Mode = 1'b1;
            if (done) dones++;
            if (busy !== (j <= W)) bad_busy++;
            if (j == W) begin
                n_cmp++;
                if ({V, Cout, S} !== exp) begin
                    n_fail++;
                    $display("FAIL ignored_start_result: V,Cout,S=%b, required %b", {V, Cout, S}, exp);
                end
            end
        end
        n_cmp++;
        if (dones !== 1 || bad_busy !== 0) begin
            n_fail++;
            $display("FAIL ignored_start_handshake: done pulses=%0d busy errors=%0d, required 1 and 0",
                     dones, bad_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] exp2;
        int           cyc;
        do_op(4'd3, 4'd4, 1'b0, cyc);
        start = 1'b1; A = 4'd9; B = 4'd2; Mode = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: busy=%b, required 0", busy);
        end
        exp2 = model(9, 2, 1);
        do_op(4'd9, 4'd2, 1'b1, cyc);
        n_cmp++;
        if (cyc !== W || {V, Cout, S} !== exp2) begin
            n_fail++;
            $display("FAIL back_to_back: cycles=%0d V,Cout,S=%b, required %0d %b", cyc, {V, Cout, S}, W, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int           cyc;
        int           dones;
        logic [W+1:0] exp;
        do_op(4'd5, 4'd3, 1'b0, cyc);
        @(negedge clk);
        start = 1'b1; A = 4'd7; B = 4'd1; Mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, S, Cout, V} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b done=%b S=%b Cout=%b V=%b, required all 0",
                     busy, done, S, Cout, V);
        end
        dones = 0;
        for (int j = 0; j < W + 3; j++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: busy/done seen %0d times, required 0", dones);
        end
        exp = model(2, 7, 1);
        do_op(4'd2, 4'd7, 1'b1, cyc);
        n_cmp++;
        if (cyc !== W || {V, Cout, S} !== exp) begin
            n_fail++;
            $display("FAIL after_reset_op: cycles=%0d V,Cout,S=%b, required %0d %b", cyc, {V, Cout, S}, W, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset;
        test_directed;
        test_random;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
